fp32_add_rr_arbiter: RTL and testbench
======================================

// Module: fp32_add_rr_arbiter
// PURPOSE
//   Shares one combinational FP32 adder (1b sign, 8b exp, 23b frac) among NUM_REQ requesters,
//   e.g. PE-column partial-sum writers. Picks one request per cycle round-robin, drives the
//   adder operands, and registers the sum with the winner's ID into a one-entry response slot.
//   Sits between the PE columns and the single adder instance at array level.
// PARAMETERS
//   NUM_REQ  4   number of requesters, 2..16
//   CNT_W    16  width of completed-operation counter
//   ID_W     localparam = max(1, $clog2(NUM_REQ)); width of requester ID
// PORTS
//   clk        in   1           clock, all state on rising edge
//   rst        in   1           synchronous reset, active-high
//   req_valid  in   NUM_REQ     per-requester operation valid
//   req_ready  out  NUM_REQ     per-requester accept; one-hot or zero
//   req_a      in   32*NUM_REQ  operand A; requester i at [32*i+31:32*i]
//   req_b      in   32*NUM_REQ  operand B; same packing
//   add_a      out  32          operand A to the shared adder
//   add_b      out  32          operand B to the shared adder
//   add_o      in   32          adder result, combinational from add_a/add_b
//   rsp_valid  out  1           response slot full
//   rsp_ready  in   1           downstream consumes the response
//   rsp_data   out  32          registered sum
//   rsp_id     out  ID_W        index of the requester that produced rsp_data
//   op_count   out  CNT_W       number of accepted operations, wraps to 0
// BEHAVIOUR
//   - Reset, sync, active-high: rsp_valid=0, rsp_data=0, rsp_id=0, op_count=0, rr_ptr=0
//     (requester 0 highest priority). While rst=1, req_ready=0 regardless of other inputs.
//   - can_accept = !rsp_valid | rsp_ready. Slot drain and refill happen in the same cycle,
//     so throughput is 1 op/cycle under no backpressure.
//   - Grant: the first i with req_valid[i]=1, searching from rr_ptr upward mod NUM_REQ.
//     req_ready[i]=1 only for the granted i, and only when can_accept.
//     req_ready is combinational from req_valid and state.
//   - Accept (req_valid[g] & req_ready[g]) in cycle N:
//       - rsp_data<=add_o, rsp_id<=g, rsp_valid<=1 at edge N+1; latency 1 cycle.
//       - rr_ptr <= (g+1) mod NUM_REQ.
//       - op_count <= op_count+1, wrapping at 2^CNT_W-1 -> 0.
//   - No accept: rr_ptr and op_count hold.
//     Slot consumed (rsp_valid & rsp_ready) with no accept: rsp_valid<=0, rsp_data/rsp_id hold.
//   - Backpressure (rsp_valid=1, rsp_ready=0): all req_ready=0; rsp_* stable until consumed.
//   - add_a/add_b = granted requester's operands when any req_valid is set, else 32'h0.
//     They follow the grant even when can_accept=0, and are don't-care to downstream.
//   - Requesters must hold req_valid/req_a/req_b until accepted.
//     A request dropped before accept is simply not served.
//   - Arbiter never alters adder results. NaN/Inf/zero/denormal handling belongs to the adder.
//   - Reset mid-operation: pending slot content is discarded, not delivered.
// STRUCTURE
//   - Shared package fp32_pkg: FP32_W=32, EXP_W=8, FRAC_W=23, FP32_ZERO=32'h0,
//     plus FP32 constants used by the benches.
//   - Sub-module rr_pick (NUM_REQ, ID_W): combinational priority picker.
//     Inputs valid vector and rr_ptr; outputs grant_any and grant_id.
//   - Top holds rr_ptr, response slot and op_count. Adder instantiated outside; top-level ties ports.
// TESTING
//   1. Reset, then req_valid=0001, a=3F800000, b=40000000, rsp_ready=1
//      -> cycle+1 rsp_valid=1, rsp_data=40400000, rsp_id=0, op_count=1.
//   2. req_valid=1111 held 8 cycles, rsp_ready=1
//      -> rsp_id sequence 0,1,2,3,0,1,2,3; op_count=8; one response per cycle.
//   3. Slot full, rsp_ready=0 for 3 cycles with req_valid=0110
//      -> req_ready=0000, rsp_data/rsp_id unchanged.
//      rsp_ready=1 -> next grant goes to the requester after the last winner.
//   4. Only requester 2 valid, continuous -> grant 2 every cycle, op_count +1 per cycle.
//      Then 0 and 3 valid with rr_ptr=3 -> 3 before 0.
//   5. rst=1 while rsp_valid=1 and req_valid=1111
//      -> next cycle all outputs 0, req_ready=0000 during rst.
//      After release, first grant is to requester 0.
//   6. CNT_W=4, 17 accepts -> op_count wraps to 1. Idle -> add_a=add_b=0.

Source files
------------

// File: rtl/fp32_pkg.sv
// FP32 shared definitions.
// Contents: field widths of the IEEE-754 single-precision format, the zero
// word driven onto an idle adder port, a handful of exact small-integer
// FP32 constants, and the requester-ID width helper used by the arbiter.
package fp32_pkg;

  localparam int FP32_W = 32;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam logic [FP32_W-1:0] FP32_ZERO    = 32'h0000_0000;
  localparam logic [FP32_W-1:0] FP32_ONE     = 32'h3F80_0000;
  localparam logic [FP32_W-1:0] FP32_TWO     = 32'h4000_0000;
  localparam logic [FP32_W-1:0] FP32_THREE   = 32'h4040_0000;
  localparam logic [FP32_W-1:0] FP32_FOUR    = 32'h4080_0000;
  localparam logic [FP32_W-1:0] FP32_FIVE    = 32'h40A0_0000;
  localparam logic [FP32_W-1:0] FP32_SIX     = 32'h40C0_0000;
  localparam logic [FP32_W-1:0] FP32_SEVEN   = 32'h40E0_0000;
  localparam logic [FP32_W-1:0] FP32_EIGHT   = 32'h4100_0000;
  localparam logic [FP32_W-1:0] FP32_ELEVEN  = 32'h4130_0000;
  localparam logic [FP32_W-1:0] FP32_FIFTEEN = 32'h4170_0000;

  // Requester-ID width, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fp32_add_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
// Ports:
//   valid     in  NUM_REQ  request vector
//   rr_ptr    in  ID_W     index holding highest priority this cycle
//   grant_any out 1        at least one request is valid
//   grant_id  out ID_W     first valid index at or after rr_ptr, modulo NUM_REQ
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               grant_any,
  output logic [ID_W-1:0]    grant_id
);

  int              idx;
  logic [ID_W-1:0] idx_id;

  // Walk from the farthest position back to rr_ptr so the nearest valid
  // request is the last one written and therefore wins, without a break.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    idx_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_id = ID_W'(idx);
      if (valid[idx_id]) begin
        grant_any = 1'b1;
        grant_id  = idx_id;
      end
    end
  end

endmodule

// File: rtl/fp32_add_rr_arbiter.sv
// fp32_add_rr_arbiter: shares one external combinational FP32 adder among
// NUM_REQ requesters. One request is granted per cycle in round-robin order,
// its operands drive the adder, and the sum is captured with the winner's ID
// into a one-entry response slot that can drain and refill in the same cycle.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  per-requester handshake (ready is one-hot or zero)
//   req_a/req_b          packed operands, requester i at [32*i +: 32]
//   add_a/add_b/add_o    shared adder operands and its combinational result
//   rsp_valid/rsp_ready  response slot handshake
//   rsp_data/rsp_id      registered sum and the requester that produced it
//   op_count             accepted-operation counter, wraps to zero
module fp32_add_rr_arbiter
  import fp32_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int CNT_W   = 16,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [FP32_W*NUM_REQ-1:0] req_a,
  input  logic [FP32_W*NUM_REQ-1:0] req_b,
  output logic [FP32_W-1:0]         add_a,
  output logic [FP32_W-1:0]         add_b,
  input  logic [FP32_W-1:0]         add_o,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [FP32_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic [CNT_W-1:0]          op_count
);

  logic [ID_W-1:0]   rr_ptr;
  logic              grant_any;
  logic [ID_W-1:0]   grant_id;
  logic              can_accept;
  logic              accept;
  logic [ID_W-1:0]   ptr_next;

  logic              vld_p1;
  logic [FP32_W-1:0] data_p1;
  logic [ID_W-1:0]   id_p1;
  logic [CNT_W-1:0]  cnt_p1;

  // Stage 0: arbitration and operand steering (combinational)
  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .valid     (req_valid),
    .rr_ptr    (rr_ptr),
    .grant_any (grant_any),
    .grant_id  (grant_id)
  );

  assign can_accept = ~vld_p1 | rsp_ready;
  assign accept     = grant_any & can_accept & ~rst;
  assign ptr_next   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  // Operands follow the grant even while the slot is blocked; the adder
  // output is simply ignored until the slot can take it.
  assign add_a = grant_any ? req_a[int'(grant_id)*FP32_W +: FP32_W] : FP32_ZERO;
  assign add_b = grant_any ? req_b[int'(grant_id)*FP32_W +: FP32_W] : FP32_ZERO;

  // Stage 1: response slot, round-robin pointer, operation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      id_p1   <= '0;
      cnt_p1  <= '0;
      rr_ptr  <= '0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= add_o;
      id_p1   <= grant_id;
      cnt_p1  <= cnt_p1 + 1'b1;
      rr_ptr  <= ptr_next;
    end else if (rsp_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_data  = data_p1;
  assign rsp_id    = id_p1;
  assign op_count  = cnt_p1;

endmodule

// File: tb/tb_fp32_add_rr_arbiter.sv
// Bench for fp32_add_rr_arbiter (NUM_REQ=4, CNT_W=4). A small FP32 adder
// model closes the add_a/add_b -> add_o loop. Stimulus pushes hand-computed
// responses into a queue; a monitor pops and compares on every consumed response.
module tb_fp32_add_rr_arbiter;
  import fp32_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a, req_b;
  logic [31:0]  add_a, add_b, add_o;
  logic         rsp_valid, rsp_ready;
  logic [31:0]  rsp_data;
  logic [1:0]   rsp_id;
  logic [3:0]   op_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  // requester i adds A_TAB[i] + B_TAB[i]; sums worked out by hand
  localparam logic [31:0] A_TAB [4] = '{FP32_ONE, FP32_THREE, FP32_FIVE, FP32_SEVEN};
  localparam logic [31:0] B_TAB [4] = '{FP32_TWO, FP32_FOUR, FP32_SIX, FP32_EIGHT};
  localparam logic [31:0] S_TAB [4] = '{32'h4040_0000, 32'h40E0_0000, 32'h4130_0000, 32'h4170_0000};

  always #5 clk = ~clk;

  fp32_add_rr_arbiter #(.NUM_REQ(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_o     (add_o),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .op_count  (op_count)
  );

  // Truncating adder for positive normal operands, enough for these vectors.
  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    logic [7:0]  ex;
    logic [24:0] mx, my, s;
    int          d;
    if (x[30:0] == 31'd0) return y;
    if (y[30:0] == 31'd0) return x;
    if (x[30:23] < y[30:23]) begin
      t = x; x = y; y = t;
    end
    ex = x[30:23];
    d  = int'(x[30:23]) - int'(y[30:23]);
    mx = {2'b01, x[22:0]};
    my = {2'b01, y[22:0]};
    my = (d > 24) ? 25'd0 : (my >> d);
    s  = mx + my;
    if (s[24]) begin
      s  = s >> 1;
      ex = ex + 8'd1;
    end
    return {1'b0, ex, s[22:0]};
  endfunction

  always_comb add_o = fp_add(add_a, add_b);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Called at a negedge: check the one-hot grant and queue its response.
  task automatic grant(input string nm, input int g);
    chk(nm, 32'(req_ready), 32'(1 << g));
    sb.push_back('{id: 2'(g), data: S_TAB[g]});
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    sb.delete();
    step();
    rst = 1'b0;
  endtask

  // Monitor: every consumed response must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id %0d data %h, expected no response", rsp_id, rsp_data);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_data", rsp_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = A_TAB[i];
      req_b[32*i +: 32] = B_TAB[i];
    end
    repeat (2) step();

    // Reset state, ready held low while in reset
    req_valid = 4'b1111;
    neg();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0;
    req_valid = 4'b0000;

    // 1: single op, 1.0 + 2.0
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    neg();
    chk("t1_add_a", add_a, 32'h3F80_0000);
    chk("t1_add_b", add_b, 32'h4000_0000);
    grant("t1_grant", 0);
    step();
    req_valid = 4'b0000;
    neg();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_op_count", 32'(op_count), 32'd1);
    step();

    // 2: all requesting, eight back-to-back grants
    apply_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      neg();
      grant("t2_grant", k % 4);
      step();
    end
    req_valid = 4'b0000;
    neg();
    chk("t2_op_count", 32'(op_count), 32'd8);
    step();
    step();

    // 3: backpressure holds the slot and blocks all grants
    apply_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    neg();
    grant("t3_first", 0);
    step();
    req_valid = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      neg();
      chk("t3_ready_blocked", 32'(req_ready), 32'd0);
      chk("t3_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t3_hold_data", rsp_data, 32'h4040_0000);
      chk("t3_hold_id", 32'(rsp_id), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    neg();
    grant("t3_after_bp", 1);
    step();
    req_valid = 4'b0100;
    neg();
    grant("t3_next", 2);
    step();
    req_valid = 4'b0000;
    step();
    step();

    // 4: lone requester 2, then 3 ahead of 0 with rr_ptr at 3
    apply_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      neg();
      chk("t4_op_count", 32'(op_count), 32'(k));
      grant("t4_grant2", 2);
      step();
    end
    req_valid = 4'b1001;
    neg();
    chk("t4_op_count", 32'(op_count), 32'd4);
    grant("t4_grant3", 3);
    step();
    req_valid = 4'b0001;
    neg();
    grant("t4_grant0", 0);
    step();
    req_valid = 4'b0000;
    neg();
    chk("t4_op_count_end", 32'(op_count), 32'd6);
    step();
    step();

    // 5: reset while the slot is full and everyone is requesting
    apply_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    neg();
    grant("t5_fill", 0);
    step();
    rst = 1'b1;
    neg();
    chk("t5_ready_in_rst", 32'(req_ready), 32'd0);
    sb.delete();
    step();
    neg();
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_rsp_data", rsp_data, 32'd0);
    chk("t5_rsp_id", 32'(rsp_id), 32'd0);
    chk("t5_op_count", 32'(op_count), 32'd0);
    chk("t5_ready_in_rst2", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0;
    rsp_ready = 1'b1;
    neg();
    grant("t5_first_after", 0);
    step();
    req_valid = 4'b0000;
    step();
    step();

    // 6: 17 accepts wrap the 4-bit counter to 1; idle operands are zero
    apply_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 17; k++) begin
      neg();
      grant("t6_grant", k % 4);
      step();
    end
    req_valid = 4'b0000;
    neg();
    chk("t6_op_count_wrap", 32'(op_count), 32'd1);
    chk("t6_idle_add_a", add_a, 32'd0);
    chk("t6_idle_add_b", add_b, 32'd0);
    step();
    step();

    neg();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
